// File: rtl/sdr_cmd_monitor.sv
// SDRAM command-bus monitor: registered command decode, bank state, tRCD/tRP/refresh checks.
// Latency 1 cycle; passive observer, no backpressure. Optional SDR_MON_RFSH_CHK_EN enables err_vec[5].
module sdr_cmd_monitor (
    input  logic        clk,
    input  logic        reset,
    input  logic        cke,
    input  logic        cs_n,
    input  logic        ras_n,
    input  logic        cas_n,
    input  logic        we_n,
    input  logic [12:0] addr,
    input  logic [1:0]  ba,
    input  logic [11:0] cfg_sdr_rfsh,
    input  logic [3:0]  cfg_trcd_d,
    input  logic [3:0]  cfg_trp_d,
    input  logic        err_clr,
    output logic [2:0]  mon_cmd,
    output logic        mon_cmd_vld,
    output logic [3:0]  bank_open,
    output logic [11:0] rfsh_cnt,
    output logic [5:0]  err_vec,
    output logic        err_pulse
);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;
    localparam logic [2:0] CMD_MRS = 3'd6;
    localparam logic [2:0] CMD_BST = 3'd7;

    logic [2:0]       cmd_d,       cmd_q;
    logic             cmd_vld_d,   cmd_vld_q;
    logic [3:0]       bank_open_d, bank_open_q;
    logic [11:0]      rfsh_cnt_d,  rfsh_cnt_q;
    logic [5:0]       err_vec_d,   err_vec_q;
    logic             err_pulse_d, err_pulse_q;
    logic [3:0][3:0]  act_age_d,   act_age_q;
    logic [3:0][3:0]  pre_age_d,   pre_age_q;
    logic [5:0]       err_set;
    logic [3:0]       pre_mask;
    logic             cmd_is_ref;
    logic             rfsh_err;
    logic             unused_addr;

    assign unused_addr = ^{addr[12:11], addr[9:0]};

    always_comb begin
        cmd_d = CMD_NOP;
        if (cke && !cs_n) begin
            case ({ras_n, cas_n, we_n})
                3'b011:  cmd_d = CMD_ACT;
                3'b101:  cmd_d = CMD_RD;
                3'b100:  cmd_d = CMD_WR;
                3'b010:  cmd_d = CMD_PRE;
                3'b001:  cmd_d = CMD_REF;
                3'b000:  cmd_d = CMD_MRS;
                3'b110:  cmd_d = CMD_BST;
                default: cmd_d = CMD_NOP;
            endcase
        end
    end

    assign cmd_vld_d  = (cmd_d != CMD_NOP);
    assign cmd_is_ref = (cmd_d == CMD_REF);
    assign pre_mask   = (cmd_d != CMD_PRE) ? 4'b0000 :
                        (addr[10] ? 4'b1111 : (4'b0001 << ba));

`ifdef SDR_MON_RFSH_CHK_EN
    // Flags the interval overrun once; re-armed only by the next REF.
    logic rfsh_done_d, rfsh_done_q;

    always_comb begin
        rfsh_err    = (rfsh_cnt_q == cfg_sdr_rfsh) && !cmd_is_ref && !rfsh_done_q;
        rfsh_done_d = cmd_is_ref ? 1'b0 : (rfsh_done_q | rfsh_err);
    end

    always_ff @(posedge clk) begin
        if (reset) rfsh_done_q <= 1'b0;
        else       rfsh_done_q <= rfsh_done_d;
    end
`else
    logic unused_cfg_rfsh;
    assign unused_cfg_rfsh = ^cfg_sdr_rfsh;
    assign rfsh_err        = 1'b0;
`endif

    always_comb begin
        bank_open_d = bank_open_q & ~pre_mask;
        err_set     = 6'b0;
        // Age 1 on the command edge means "one edge ago" when the next command is sampled.
        for (int i = 0; i < 4; i++) begin
            act_age_d[i] = (act_age_q[i] == 4'hF) ? 4'hF : act_age_q[i] + 4'd1;
            pre_age_d[i] = pre_mask[i] ? 4'd1 :
                           ((pre_age_q[i] == 4'hF) ? 4'hF : pre_age_q[i] + 4'd1);
        end
        case (cmd_d)
            CMD_ACT: begin
                err_set[1]     = bank_open_q[ba];
                err_set[3]     = (cfg_trp_d != 4'd0) && (pre_age_q[ba] < cfg_trp_d);
                bank_open_d[ba] = 1'b1;
                act_age_d[ba]  = 4'd1;
            end
            CMD_RD, CMD_WR: begin
                err_set[0] = !bank_open_q[ba];
                err_set[2] = (cfg_trcd_d != 4'd0) && (act_age_q[ba] < cfg_trcd_d);
            end
            CMD_REF: err_set[4] = |bank_open_q;
            default: ;
        endcase
        err_set[5]  = rfsh_err;
        rfsh_cnt_d  = cmd_is_ref ? 12'd0 :
                      ((rfsh_cnt_q == 12'hFFF) ? 12'hFFF : rfsh_cnt_q + 12'd1);
        // A new error outranks a simultaneous clear.
        err_vec_d   = (err_clr ? 6'b0 : err_vec_q) | err_set;
        err_pulse_d = |(err_set & ~err_vec_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q       <= CMD_NOP;
            cmd_vld_q   <= 1'b0;
            bank_open_q <= 4'b0;
            rfsh_cnt_q  <= 12'd0;
            err_vec_q   <= 6'b0;
            err_pulse_q <= 1'b0;
            act_age_q   <= {4{4'hF}};
            pre_age_q   <= {4{4'hF}};
        end else begin
            cmd_q       <= cmd_d;
            cmd_vld_q   <= cmd_vld_d;
            bank_open_q <= bank_open_d;
            rfsh_cnt_q  <= rfsh_cnt_d;
            err_vec_q   <= err_vec_d;
            err_pulse_q <= err_pulse_d;
            act_age_q   <= act_age_d;
            pre_age_q   <= pre_age_d;
        end
    end

    assign mon_cmd     = cmd_q;
    assign mon_cmd_vld = cmd_vld_q;
    assign bank_open   = bank_open_q;
    assign rfsh_cnt    = rfsh_cnt_q;
    assign err_vec     = err_vec_q;
    assign err_pulse   = err_pulse_q;

endmodule

// File: tb/tb_sdr_cmd_monitor.sv
// Bench for sdr_cmd_monitor: timestamp-based reference model checked every cycle plus directed literal checks.
module tb_sdr_cmd_monitor;

    logic        clk = 1'b0;
    logic        reset, cke, cs_n, ras_n, cas_n, we_n, err_clr;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic [11:0] cfg_sdr_rfsh;
    logic [3:0]  cfg_trcd_d, cfg_trp_d;
    logic [2:0]  mon_cmd;
    logic        mon_cmd_vld, err_pulse;
    logic [3:0]  bank_open;
    logic [11:0] rfsh_cnt;
    logic [5:0]  err_vec;

    localparam logic [2:0] P_ACT = 3'b011, P_RD = 3'b101, P_WR = 3'b100, P_PRE = 3'b010;
    localparam logic [2:0] P_REF = 3'b001, P_MRS = 3'b000, P_BST = 3'b110, P_NOP = 3'b111;

    int checks = 0;
    int errors = 0;

    sdr_cmd_monitor dut (
        .clk(clk), .reset(reset), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
        .we_n(we_n), .addr(addr), .ba(ba), .cfg_sdr_rfsh(cfg_sdr_rfsh),
        .cfg_trcd_d(cfg_trcd_d), .cfg_trp_d(cfg_trp_d), .err_clr(err_clr),
        .mon_cmd(mon_cmd), .mon_cmd_vld(mon_cmd_vld), .bank_open(bank_open),
        .rfsh_cnt(rfsh_cnt), .err_vec(err_vec), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: remembers when each bank was last activated/precharged and when
    // the last REF happened, and derives distances by subtracting edge numbers.
    int   cyc = 0;
    int   last_act [4];
    int   last_pre [4];
    bit   bank_st  [4];
    int   rf_last;
    bit   rf_reported;
    bit   model_ok = 1'b0;
    logic [2:0]  e_cmd;
    logic        e_vld, e_pulse;
    logic [3:0]  e_open;
    logic [11:0] e_rfsh;
    logic [5:0]  e_err;

    function automatic logic [2:0] decode(input logic k, input logic cs, input logic [2:0] rcw);
        if (!k || cs) return 3'd0;
        case (rcw)
            P_ACT: return 3'd1;
            P_RD:  return 3'd2;
            P_WR:  return 3'd3;
            P_PRE: return 3'd4;
            P_REF: return 3'd5;
            P_MRS: return 3'd6;
            P_BST: return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    function automatic int clamp4095(input int v);
        return (v > 4095) ? 4095 : v;
    endfunction

    always @(posedge clk) begin
        logic [2:0] c;
        logic [5:0] s;
        int b;
        cyc++;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                last_act[i] = -1000; last_pre[i] = -1000; bank_st[i] = 1'b0;
            end
            rf_last = cyc; rf_reported = 1'b0;
            e_cmd = 0; e_vld = 0; e_pulse = 0; e_err = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            c = decode(cke, cs_n, {ras_n, cas_n, we_n});
            b = int'(ba);
            s = 6'b0;
            if (c == 3'd1) begin
                if (bank_st[b]) s[1] = 1'b1;
                if (cfg_trp_d != 0 && (cyc - last_pre[b]) < int'(cfg_trp_d)) s[3] = 1'b1;
                bank_st[b] = 1'b1; last_act[b] = cyc;
            end else if (c == 3'd2 || c == 3'd3) begin
                if (!bank_st[b]) s[0] = 1'b1;
                if (cfg_trcd_d != 0 && (cyc - last_act[b]) < int'(cfg_trcd_d)) s[2] = 1'b1;
            end else if (c == 3'd4) begin
                for (int i = 0; i < 4; i++)
                    if (addr[10] || i == b) begin bank_st[i] = 1'b0; last_pre[i] = cyc; end
            end else if (c == 3'd5) begin
                if (bank_st[0] || bank_st[1] || bank_st[2] || bank_st[3]) s[4] = 1'b1;
            end
`ifdef SDR_MON_RFSH_CHK_EN
            if (c != 3'd5 && !rf_reported && clamp4095(cyc - 1 - rf_last) == int'(cfg_sdr_rfsh)) begin
                s[5] = 1'b1; rf_reported = 1'b1;
            end
`endif
            if (c == 3'd5) begin rf_last = cyc; rf_reported = 1'b0; end
            e_cmd   = c;
            e_vld   = (c != 3'd0);
            e_pulse = |(s & ~e_err);
            e_err   = (err_clr ? 6'b0 : e_err) | s;
        end
        for (int i = 0; i < 4; i++) e_open[i] = bank_st[i];
        e_rfsh = 12'(clamp4095(cyc - rf_last));
        #1;
        if (model_ok) begin
            chk("cyc_mon_cmd",   mon_cmd,     e_cmd);
            chk("cyc_cmd_vld",   mon_cmd_vld, e_vld);
            chk("cyc_bank_open", bank_open,   e_open);
            chk("cyc_rfsh_cnt",  rfsh_cnt,    e_rfsh);
            chk("cyc_err_vec",   err_vec,     e_err);
            chk("cyc_err_pulse", err_pulse,   e_pulse);
        end
    end

    task automatic issue(input logic [2:0] rcw, input logic [1:0] b, input logic a10, input logic clr);
        cs_n = 1'b0; {ras_n, cas_n, we_n} = rcw; ba = b;
        addr = {2'b00, a10, 10'b0}; err_clr = clr;
        @(negedge clk);
        cs_n = 1'b1; {ras_n, cas_n, we_n} = P_NOP; err_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = P_NOP;
        addr = '0; ba = '0; err_clr = 1'b0;
        cfg_sdr_rfsh = 12'd4000; cfg_trcd_d = 4'd3; cfg_trp_d = 4'd2;
        idle(3);
        chk("rst_mon_cmd",   mon_cmd,     0);
        chk("rst_cmd_vld",   mon_cmd_vld, 0);
        chk("rst_bank_open", bank_open,   0);
        chk("rst_err_vec",   err_vec,     0);
        chk("rst_rfsh_cnt",  rfsh_cnt,    0);
        reset = 1'b0;

        issue(P_ACT, 2'd1, 1'b0, 1'b0); idle(2); issue(P_RD, 2'd1, 1'b0, 1'b0);
        chk("t031_mon_cmd", mon_cmd, 3'd2);
        chk("t031_open",    bank_open, 4'b0010);
        chk("t031_err",     err_vec, 6'b0);

        issue(P_ACT, 2'd2, 1'b0, 1'b0); idle(1); issue(P_WR, 2'd2, 1'b0, 1'b0);
        chk("t032_err",    err_vec, 6'b000100);
        chk("t032_pulse",  err_pulse, 1'b1);
        chk("t032_open",   bank_open, 4'b0110);
        idle(1);
        chk("t032_pulse_drop", err_pulse, 1'b0);
        chk("t032_sticky",     err_vec, 6'b000100);
        issue(P_NOP, 2'd0, 1'b0, 1'b1);
        chk("clr1_err", err_vec, 6'b0);

        issue(P_ACT, 2'd0, 1'b0, 1'b0); issue(P_ACT, 2'd3, 1'b0, 1'b0);
        chk("t033_all_open", bank_open, 4'b1111);
        issue(P_PRE, 2'd1, 1'b1, 1'b0);
        chk("t033_pre_all", bank_open, 4'b0000);
        issue(P_ACT, 2'd0, 1'b0, 1'b0);
        chk("t033_err",  err_vec, 6'b001000);
        chk("t033_open", bank_open, 4'b0001);
        issue(P_PRE, 2'd0, 1'b0, 1'b0); idle(1); issue(P_ACT, 2'd0, 1'b0, 1'b0);
        chk("trp_edge_pulse", err_pulse, 1'b0);
        chk("trp_edge_err",   err_vec, 6'b001000);
        issue(P_NOP, 2'd0, 1'b0, 1'b1);

        issue(P_BST, 2'd0, 1'b0, 1'b0);
        chk("bst_cmd", mon_cmd, 3'd7);
        issue(P_MRS, 2'd0, 1'b0, 1'b0);
        chk("mrs_cmd", mon_cmd, 3'd6);
        cke = 1'b0; issue(P_RD, 2'd3, 1'b0, 1'b0); cke = 1'b1;
        chk("cke_low_vld", mon_cmd_vld, 1'b0);
        chk("cke_low_err", err_vec, 6'b0);

        issue(P_REF, 2'd0, 1'b0, 1'b0);
        chk("ref_open_err", err_vec, 6'b010000);
        chk("ref_rfsh",     rfsh_cnt, 12'd0);
        issue(P_PRE, 2'd0, 1'b1, 1'b0); issue(P_NOP, 2'd0, 1'b0, 1'b1);
        issue(P_REF, 2'd0, 1'b0, 1'b0);
        chk("ref_closed_err", err_vec, 6'b0);

        issue(P_RD, 2'd0, 1'b0, 1'b1);
        chk("t035_err", err_vec, 6'b000001);
        issue(P_NOP, 2'd0, 1'b0, 1'b1);
        chk("t035_clr", err_vec, 6'b0);

        cfg_trcd_d = 4'd0;
        issue(P_ACT, 2'd2, 1'b0, 1'b0); issue(P_RD, 2'd2, 1'b0, 1'b0);
        chk("trcd_off_err", err_vec, 6'b0);
        cfg_trcd_d = 4'd3;
        issue(P_PRE, 2'd0, 1'b1, 1'b0);

        issue(P_ACT, 2'd1, 1'b0, 1'b0);
        reset = 1'b1; issue(P_ACT, 2'd2, 1'b0, 1'b0); reset = 1'b0;
        cfg_sdr_rfsh = 12'd100;
        chk("t036_open", bank_open, 4'b0);
        chk("t036_rfsh", rfsh_cnt, 12'd0);
        issue(P_RD, 2'd1, 1'b0, 1'b0);
        chk("t036_err",   err_vec, 6'b000001);
        chk("t036_pulse", err_pulse, 1'b1);
        issue(P_NOP, 2'd0, 1'b0, 1'b1);
        idle(98);
        chk("t034_cnt100", rfsh_cnt, 12'd100);
        chk("t034_before", err_vec, 6'b0);
        idle(1);
`ifdef SDR_MON_RFSH_CHK_EN
        chk("t034_err5",  err_vec, 6'b100000);
        chk("t034_pulse", err_pulse, 1'b1);
`else
        chk("t034_err5",  err_vec, 6'b0);
        chk("t034_pulse", err_pulse, 1'b0);
`endif
        issue(P_REF, 2'd0, 1'b0, 1'b0);
        chk("t034_ref_rfsh", rfsh_cnt, 12'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
